// File: rtl/jk_bank_arbiter_if.sv
// Requester handshake and bank status bundle for jk_bank_arbiter.
// slave = arbiter side, master = requester/observer side.
interface jk_bank_arbiter_if #(
    parameter int N  = 8,
    parameter int AW = 3
);
    logic          a_valid, a_ready, a_j, a_k;
    logic [AW-1:0] a_addr;
    logic          b_valid, b_ready, b_j, b_k;
    logic [AW-1:0] b_addr;
    logic [N-1:0]  q, qb;
    logic          done, done_src, err;
    logic [AW-1:0] done_addr;

    modport slave (
        input  a_valid, a_addr, a_j, a_k, b_valid, b_addr, b_j, b_k,
        output a_ready, b_ready, q, qb, done, done_src, done_addr, err
    );
    modport master (
        output a_valid, a_addr, a_j, a_k, b_valid, b_addr, b_j, b_k,
        input  a_ready, b_ready, q, qb, done, done_src, done_addr, err
    );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Two-requester round-robin arbiter applying buffered JK commands to a bank of N bits.
// One command slot per requester; at most one grant per cycle.
module jk_bank_arbiter_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= 1'b0;
        else if (en) begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end
endmodule

module jk_bank_arbiter #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    jk_bank_arbiter_if.slave   bus
);
    localparam logic [31:0] NU = 32'(N);

    logic          pend_a, pend_b, last_b;
    logic [AW-1:0] addr_a, addr_b;
    logic          j_a, k_a, j_b, k_b;
    logic          grant_a, grant_b, gnt, in_range, g_j, g_k;
    logic [AW-1:0] g_addr;
    logic [N-1:0]  q, cell_en;
    logic          done_r, src_r, err_r;
    logic [AW-1:0] daddr_r;

    // last_b=1 after reset so A takes the first contention
    always_comb begin
        grant_a  = pend_a && (!pend_b || last_b);
        grant_b  = pend_b && !grant_a;
        gnt      = grant_a || grant_b;
        g_addr   = grant_b ? addr_b : addr_a;
        g_j      = grant_b ? j_b : j_a;
        g_k      = grant_b ? k_b : k_a;
        in_range = {{(32-AW){1'b0}}, g_addr} < NU;
    end

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign cell_en[i] = gnt && in_range && (g_addr == AW'(i));
        jk_bank_arbiter_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (cell_en[i]),
            .j     (g_j),
            .k     (g_k),
            .q     (q[i])
        );
    end

    // Accept and grant of one slot never coincide: ready is low while pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_a <= 1'b0;  pend_b <= 1'b0;
            addr_a <= '0;    addr_b <= '0;
            j_a    <= 1'b0;  k_a    <= 1'b0;
            j_b    <= 1'b0;  k_b    <= 1'b0;
            last_b <= 1'b1;
        end else begin
            if (bus.a_valid && !pend_a) begin
                pend_a <= 1'b1;
                addr_a <= bus.a_addr; j_a <= bus.a_j; k_a <= bus.a_k;
            end else if (grant_a) pend_a <= 1'b0;
            if (bus.b_valid && !pend_b) begin
                pend_b <= 1'b1;
                addr_b <= bus.b_addr; j_b <= bus.b_j; k_b <= bus.b_k;
            end else if (grant_b) pend_b <= 1'b0;
            if (gnt) last_b <= grant_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_r  <= 1'b0;
            src_r   <= 1'b0;
            daddr_r <= '0;
            err_r   <= 1'b0;
        end else begin
            done_r <= gnt && in_range;
            err_r  <= gnt && !in_range;
            if (gnt && in_range) begin
                src_r   <= grant_b;
                daddr_r <= g_addr;
            end
        end
    end

    assign bus.a_ready   = !pend_a;
    assign bus.b_ready   = !pend_b;
    assign bus.q         = q;
    assign bus.qb        = ~q;
    assign bus.done      = done_r;
    assign bus.done_src  = src_r;
    assign bus.done_addr = daddr_r;
    assign bus.err       = err_r;
endmodule
